// File: rtl/chop_integrator_if.sv
// ----------------------------------------------------------------------------
// chop_integrator_if
//
// Bundles the sample stream, control and result signals of one
// chop_integrator channel.
//
// Parameters:
//   ADC_W : signed ADC sample width
//   ACC_W : signed accumulator width
//
// Modports:
//   master : the upstream side. It drives the enable, the ADC sample stream,
//            the delayed chop phase/hold flags and the offset, and reads back
//            the integral, the strobe, the flags and the counters.
//   slave  : the integrator itself, with the opposite directions.
// ----------------------------------------------------------------------------
interface chop_integrator_if #(
    parameter int ADC_W = 18,
    parameter int ACC_W = 32
);
    logic                    integ_en;
    logic signed [ADC_W-1:0] adc_data_i;
    logic                    adc_valid_i;
    logic                    chop_dly_i;
    logic                    data_hold_i;
    logic signed [ADC_W-1:0] offset_i;
    logic signed [ACC_W-1:0] integral_o;
    logic                    integral_valid_o;
    logic                    sat_o;
    logic [31:0]             sample_cnt_o;
    logic [31:0]             hold_cnt_o;
    logic                    running_o;

    modport master (
        output integ_en, adc_data_i, adc_valid_i, chop_dly_i, data_hold_i, offset_i,
        input  integral_o, integral_valid_o, sat_o, sample_cnt_o, hold_cnt_o, running_o
    );

    modport slave (
        input  integ_en, adc_data_i, adc_valid_i, chop_dly_i, data_hold_i, offset_i,
        output integral_o, integral_valid_o, sat_o, sample_cnt_o, hold_cnt_o, running_o
    );
endinterface

// File: rtl/chop_integrator.sv
// ----------------------------------------------------------------------------
// chop_integrator
//
// Chopper demodulator and saturating integrator for one interlock channel.
// Each valid ADC sample has the offset removed, is multiplied by +1/-1 by the
// delayed chop phase and is added to a saturating signed integral. Samples
// flagged by the delayed hold flag are only counted, never accumulated.
//
// Pipeline: stage 1 registers the sample/phase/hold/valid and subtracts the
// offset, stage 2 applies the sign, stage 3 accumulates and saturates, so a
// sample shows up on integral_o three clocks after its adc_valid_i.
//
// Optional feature macro: CHOP_INTEGRATOR_OFFSET_EN
//   defined   : offset_i is captured on IDLE->ARMED and subtracted in stage 1.
//   undefined : offset_i is ignored (offset of 0); pipeline depth unchanged.
//
// Ports:
//   clk : sample clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : chop_integrator_if.slave (integ_en, adc_data_i, adc_valid_i,
//         chop_dly_i, data_hold_i, offset_i in; integral_o, integral_valid_o,
//         sat_o, sample_cnt_o, hold_cnt_o, running_o out)
// ----------------------------------------------------------------------------
module chop_integrator #(
    parameter int ADC_W = 18,
    parameter int ACC_W = 32
) (
    input logic               clk,
    input logic               rst,
    chop_integrator_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic                    arm_s;
    logic                    trig_s;
    logic                    accept_s;
    logic                    last_hold_r;

    logic signed [ADC_W-1:0] offset_s;
    logic signed [ADC_W:0]   diff_s;
    logic                    s1_valid_r;
    logic                    s1_chop_r;
    logic                    s1_hold_r;
    logic signed [ADC_W:0]   s1_d_r;

    logic signed [ADC_W+1:0] d_ext_s;
    logic signed [ADC_W+1:0] m_s;
    logic                    s2_valid_r;
    logic                    s2_hold_r;
    logic signed [ADC_W+1:0] s2_m_r;

    logic                    upd_s;
    logic signed [ACC_W:0]   sum_s;
    logic                    ovf_s;
    logic signed [ACC_W-1:0] sum_sat_s;
    logic signed [ACC_W-1:0] acc_r;
    logic                    iv_r;
    logic                    sat_r;
    logic [31:0]             scnt_r;
    logic [31:0]             hcnt_r;
    logic                    running_r;

`ifdef CHOP_INTEGRATOR_OFFSET_EN
    logic signed [ADC_W-1:0] offset_r;

    // Offset is frozen at arm time so it cannot move during a measurement
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            offset_r <= {ADC_W{1'b0}};
        end else if (arm_s) begin
            offset_r <= bus.offset_i;
        end
    end

    assign offset_s = offset_r;
`else
    logic unused_offset_s;

    assign unused_offset_s = ^bus.offset_i;
    assign offset_s        = {ADC_W{1'b0}};
`endif

    // One extra bit so sample minus offset never wraps
    assign diff_s = (ADC_W+1)'(bus.adc_data_i) - (ADC_W+1)'(offset_s);

    // Stage 1: register sample, phase, hold and strobe together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_chop_r  <= 1'b0;
            s1_hold_r  <= 1'b0;
            s1_d_r     <= {(ADC_W+1){1'b0}};
        end else begin
            s1_valid_r <= bus.adc_valid_i;
            s1_chop_r  <= bus.chop_dly_i;
            s1_hold_r  <= bus.data_hold_i;
            s1_d_r     <= diff_s;
        end
    end

    // FSM next state; decisions are taken on stage-1 data
    always_comb begin
        state_s = state_r;
        arm_s   = 1'b0;
        trig_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.integ_en) begin
                    state_s = ST_ARMED;
                    arm_s   = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                // Start only on a held->unheld boundary of the chop sequence
                if (!bus.integ_en) begin
                    state_s = ST_IDLE;
                end else if (s1_valid_r && !s1_hold_r && last_hold_r) begin
                    state_s = ST_RUN;
                    trig_s  = 1'b1;
                end else begin
                    state_s = ST_ARMED;
                end
            end
            ST_RUN: begin
                if (!bus.integ_en) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        // The boundary sample that triggers RUN is itself accumulated
        accept_s = bus.integ_en && s1_valid_r && ((state_r == ST_RUN) || trig_s);
    end

    // FSM state, hold flag of the last valid armed sample, running flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            last_hold_r <= 1'b0;
            running_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            running_r <= (state_s == ST_RUN);
            if (arm_s) begin
                last_hold_r <= 1'b0;
            end else if ((state_r == ST_ARMED) && s1_valid_r) begin
                last_hold_r <= s1_hold_r;
            end
        end
    end

    // Demodulation sign; two extra bits keep -(most negative diff) exact
    always_comb begin
        d_ext_s = (ADC_W+2)'(s1_d_r);
        if (s1_chop_r) begin
            m_s = -d_ext_s;
        end else begin
            m_s = d_ext_s;
        end
    end

    // Stage 2: signed, demodulated sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            s2_hold_r  <= 1'b0;
            s2_m_r     <= {(ADC_W+2){1'b0}};
        end else begin
            s2_valid_r <= accept_s;
            s2_hold_r  <= s1_hold_r;
            s2_m_r     <= m_s;
        end
    end

    // Stage 3 sum with one guard bit and clamp to the accumulator range
    always_comb begin
        // Dropping integ_en discards whatever is still in stage 2
        upd_s = s2_valid_r && bus.integ_en;
        sum_s = (ACC_W+1)'(acc_r) + (ACC_W+1)'(s2_m_r);
        ovf_s = sum_s[ACC_W] ^ sum_s[ACC_W-1];
        if (!ovf_s) begin
            sum_sat_s = sum_s[ACC_W-1:0];
        end else if (sum_s[ACC_W]) begin
            sum_sat_s = {1'b1, {(ACC_W-1){1'b0}}};
        end else begin
            sum_sat_s = {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    // Stage 3: accumulator, sticky saturation, counters and result strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r  <= {ACC_W{1'b0}};
            iv_r   <= 1'b0;
            sat_r  <= 1'b0;
            scnt_r <= 32'd0;
            hcnt_r <= 32'd0;
        end else begin
            iv_r <= 1'b0;
            if (arm_s) begin
                acc_r  <= {ACC_W{1'b0}};
                sat_r  <= 1'b0;
                scnt_r <= 32'd0;
                hcnt_r <= 32'd0;
            end else if (upd_s) begin
                if (s2_hold_r) begin
                    hcnt_r <= hcnt_r + 32'd1;
                end else begin
                    acc_r  <= sum_sat_s;
                    scnt_r <= scnt_r + 32'd1;
                    iv_r   <= 1'b1;
                    if (ovf_s) begin
                        sat_r <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.integral_o       = acc_r;
    assign bus.integral_valid_o = iv_r;
    assign bus.sat_o            = sat_r;
    assign bus.sample_cnt_o     = scnt_r;
    assign bus.hold_cnt_o       = hcnt_r;
    assign bus.running_o        = running_r;

endmodule
